// File: rtl/icache_refill_engine.sv
// icache_refill_engine: blocking set-associative I-cache with its own tag/valid/data
// arrays and an autonomous miss/refill controller. Optional ICACHE_PERF_CNT_EN adds
// hit/miss counters (ports read 0 when the macro is undefined).
// Ports: clk, rst (sync, active-low), flush; req_valid/req_addr/req_ready fetch side;
// resp_valid/resp_data response; mem_req_valid/ready/addr fill request;
// mem_rsp_valid/data refill beats; hit_count/miss_count statistics.
module icache_refill_engine #(
  parameter int DATA_LENGTH   = 32,
  parameter int CACHE_SIZE    = 4096,
  parameter int LINE_SIZE     = 32,
  parameter int WAYS          = 2,
  parameter int MEM_BEAT_BITS = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     req_valid,
  input  logic [31:0]              req_addr,
  output logic                     req_ready,
  output logic                     resp_valid,
  output logic [DATA_LENGTH-1:0]   resp_data,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [31:0]              mem_req_addr,
  input  logic                     mem_rsp_valid,
  input  logic [MEM_BEAT_BITS-1:0] mem_rsp_data,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
);

  localparam int SETS  = CACHE_SIZE / (LINE_SIZE * WAYS);
  localparam int OFFW  = $clog2(LINE_SIZE);
  localparam int IDXW  = $clog2(SETS);
  localparam int TAGW  = 32 - OFFW - IDXW;
  localparam int LBITS = LINE_SIZE * 8;
  localparam int BEATS = LBITS / MEM_BEAT_BITS;
  localparam int WOB   = $clog2(DATA_LENGTH / 8);
  localparam int WIW   = OFFW - WOB;
  localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_REQ,
    S_REFILL,
    S_RESPOND,
    S_DRAIN
  } state_t;

  state_t                 state_q, state_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            maddr_q, maddr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   pend_q, pend_d;
  logic [LBITS-1:0]       line_q, line_d;
  logic [DATA_LENGTH-1:0] rdata_q, rdata_d;

  logic                   valid_q [WAYS][SETS];
  logic [TAGW-1:0]        tag_q   [WAYS][SETS];
  logic [LBITS-1:0]       data_q  [WAYS][SETS];
  logic [WW-1:0]          rr_q    [SETS];

  logic [IDXW-1:0]        idx;
  logic [TAGW-1:0]        tag;
  logic [WIW-1:0]         widx;
  logic                   hit;
  logic [DATA_LENGTH-1:0] hit_word;
  logic [DATA_LENGTH-1:0] buf_word;
  logic [DATA_LENGTH-1:0] resp_word;
  logic [WW-1:0]          vic;
  logic                   any_inv;
  logic                   install;
  logic                   hit_ev;
  logic                   miss_ev;
  logic                   last_beat;
  logic                   unused_lsb;

  assign idx        = addr_q[OFFW +: IDXW];
  assign tag        = addr_q[31 -: TAGW];
  assign widx       = addr_q[WOB +: WIW];
  assign unused_lsb = ^addr_q[WOB-1:0];
  assign last_beat  = (cnt_q == CW'(BEATS - 1));
  assign buf_word   = line_q[int'(widx)*DATA_LENGTH +: DATA_LENGTH];

  always_comb begin
    hit      = 1'b0;
    hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][idx] && tag_q[w][idx] == tag) begin
        hit      = 1'b1;
        hit_word = data_q[w][idx][int'(widx)*DATA_LENGTH +: DATA_LENGTH];
      end
    end
  end

  // Descending scan so the lowest invalid way wins; else round-robin.
  always_comb begin
    vic     = rr_q[idx];
    any_inv = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][idx]) begin
        vic     = WW'(w);
        any_inv = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    maddr_d       = maddr_q;
    cnt_d         = cnt_q;
    pend_d        = pend_q;
    line_d        = line_q;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_word     = hit_word;
    mem_req_valid = 1'b0;
    install       = 1'b0;
    hit_ev        = 1'b0;
    miss_ev       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = !flush;
        if (req_valid && !flush) begin
          addr_d  = req_addr;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (hit) begin
          resp_valid = 1'b1;
          hit_ev     = 1'b1;
          req_ready  = 1'b1;
          if (req_valid) begin
            addr_d  = req_addr;
            state_d = S_LOOKUP;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          miss_ev = 1'b1;
          maddr_d = {addr_q[31:OFFW], {OFFW{1'b0}}};
          state_d = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          cnt_d   = '0;
          pend_d  = 1'b0;
          state_d = flush ? S_DRAIN : S_REFILL;
        end else if (flush) begin
          pend_d  = 1'b1;
          state_d = S_DRAIN;
        end
      end
      S_REFILL: begin
        if (mem_rsp_valid) begin
          line_d[int'(cnt_q)*MEM_BEAT_BITS +: MEM_BEAT_BITS] = mem_rsp_data;
          if (last_beat) begin
            cnt_d   = '0;
            install = !flush;
            state_d = flush ? S_IDLE : S_RESPOND;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (flush) state_d = S_DRAIN;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_RESPOND: begin
        state_d = S_IDLE;
        if (!flush) begin
          resp_valid = 1'b1;
          resp_word  = buf_word;
        end
      end
      S_DRAIN: begin
        // A still-pending request must finish its handshake before
        // the beats it triggers can be absorbed.
        if (pend_q) begin
          mem_req_valid = 1'b1;
          if (mem_req_ready) begin
            pend_d = 1'b0;
            cnt_d  = '0;
          end
        end else if (mem_rsp_valid) begin
          if (last_beat) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rdata_d      = resp_valid ? resp_word : rdata_q;
  assign resp_data    = rdata_d;
  assign mem_req_addr = maddr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      maddr_q <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      line_q  <= '0;
      rdata_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) valid_q[w][s] <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      maddr_q <= maddr_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      line_q  <= line_d;
      rdata_q <= rdata_d;
      if (flush) begin
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++) valid_q[w][s] <= 1'b0;
      end else if (install) begin
        valid_q[vic][idx] <= 1'b1;
        if (!any_inv)
          rr_q[idx] <= (rr_q[idx] == WW'(WAYS - 1)) ? '0 : rr_q[idx] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && install) begin
      data_q[vic][idx] <= line_d;
      tag_q[vic][idx]  <= tag;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_q;
  logic [31:0] miss_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (hit_ev)  hit_q  <= hit_q + 32'd1;
      if (miss_ev) miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  logic unused_ev;
  assign unused_ev  = hit_ev ^ miss_ev;
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: doc/icache_refill_engine.md
Name: icache_refill_engine

Overview:
Self-contained, blocking, set-associative instruction cache with its own tag, valid and data arrays, plus an integrated miss/refill state machine. The fetch stage issues word requests and gets registered hit responses. On a miss, the block requests the line from the memory side and refills it over MEM_BEAT_BITS-wide beats, then responds. It generalises the earlier wrapper-only cache, which had externally driven refill, into a parametrised cache with an autonomous controller.

Parameters:
DATA_LENGTH, 32, fetch word width in bits (power of 2, ≥32)
CACHE_SIZE, 4096, total data capacity in bytes
LINE_SIZE, 32, line size in bytes
WAYS, 2, associativity (power of 2, ≥1)
MEM_BEAT_BITS, 64, memory return beat width; LINE_SIZE*8 must be a multiple of it

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  synchronous active-low reset
flush  in  1  invalidate all lines; single-cycle pulse
req_valid  in  1  fetch request valid
req_addr  in  32  byte address; low log2(DATA_LENGTH/8) bits ignored
req_ready  out  1  request accepted when req_valid && req_ready
resp_valid  out  1  one-cycle response strobe
resp_data  out  DATA_LENGTH  fetched word
mem_req_valid  out  1  line-fill request
mem_req_ready  in  1  memory accepts the request
mem_req_addr  out  32  line-aligned fill address
mem_rsp_valid  in  1  beat valid; there is no backpressure
mem_rsp_data  in  MEM_BEAT_BITS  beat payload, lowest address first
hit_count  out  32  hit counter (see Optional Feature)
miss_count  out  32  miss counter (see Optional Feature)

Behaviour:
- Geometry:
  - SETS = CACHE_SIZE/(LINE_SIZE*WAYS)
  - offset = log2(LINE_SIZE)
  - index = log2(SETS)
  - tag = 32-offset-index
  - BEATS = LINE_SIZE*8/MEM_BEAT_BITS
- Reset (rst==0 at a clock edge), from any state including mid-refill:
  - state=IDLE; all valid bits=0; round-robin pointers=0
  - resp_valid=0, resp_data=0, mem_req_valid=0, mem_req_addr=0, counters=0
  - Memory beats arriving after reset are ignored.
- States and transitions:
  - IDLE: req_ready=1. Accept → latch address → LOOKUP.
  - LOOKUP: tag compare across all ways.
    - Hit: resp_valid=1 and resp_data=word in this cycle, so latency is 1 cycle after acceptance. req_ready=1, so back-to-back hits stream at 1/cycle. Next state is LOOKUP if a new request is accepted, else IDLE.
    - Miss: req_ready=0 → MISS_REQ.
  - MISS_REQ: mem_req_valid=1, mem_req_addr={tag,index,0}. Held stable until mem_req_ready, then → REFILL with beat counter=0.
  - REFILL: each mem_rsp_valid writes beat k into the line buffer; the counter increments. On beat BEATS-1: write the line into the victim way, set tag and valid → RESPOND.
  - RESPOND: resp_valid=1 with the requested word taken from the line buffer → IDLE.
  - DRAIN: absorbs remaining beats, or first completes a still-pending mem request. Nothing is installed → IDLE.
- Victim selection:
  - Lowest-index invalid way first.
  - Otherwise the set's round-robin pointer, which increments modulo WAYS only when it is used.
- Multi-way hits cannot occur and are not checked.
- resp_valid is 0 in every state and cycle other than those listed above. resp_data holds its last value.
- flush (highest priority after reset):
  - Clears all valid bits in the same cycle.
  - In LOOKUP or RESPOND: suppresses that cycle's resp_valid and the request is dropped → IDLE. A request coincident with flush is not accepted (req_ready=0).
  - In MISS_REQ or REFILL → DRAIN. mem_req_valid stays asserted until its handshake, because valid must never drop before ready.
  - In DRAIN or IDLE: valid bits are cleared only.
- The final refill beat coincident with flush goes to DRAIN-complete → IDLE with no install.
- The beat counter wraps at BEATS. Excess beats in IDLE are ignored.

Optional Feature:
Macro ICACHE_PERF_CNT_EN.
- Defined: hit_count increments on each LOOKUP hit, miss_count on each LOOKUP miss. Both are 32-bit, wrap from 0xFFFFFFFF to 0, and are cleared by rst only (not by flush).
- Undefined: counter logic is absent and both ports are constant 0.

Test Plan:
- Reset, then req 0x0000_1004 miss → mem_req_addr=0x0000_1000. Beats 0x1111_1111_0000_0000, 0x3333_3333_2222_2222, ... → resp_data=0x1111_1111 in RESPOND. Then req 0x0000_1008 → hit, resp_data=0x2222_2222 one cycle after accept.
- Back-to-back hits 0x1000, 0x1004, 0x1008, 0x100C with req_valid held → four consecutive resp_valid cycles, req_ready=1 throughout.
- Three misses to set 0 (0x0000, 0x0800, 0x1000), default geometry: way0, way1, then way0 evicted → re-request 0x0000 misses, 0x0800 hits.
- Flush asserted after the 2nd of 4 beats → state DRAIN, beats 3-4 absorbed, no resp_valid; re-request of the same address misses again.
- rst=0 mid-REFILL → all outputs return to reset values the next cycle; stray beats are ignored; next request misses.
- With ICACHE_PERF_CNT_EN: 1 miss + 3 hits → miss_count=1, hit_count=3. Without the macro: both read 0.
